swizzle_c2d_pingpong: RTL and testbench

SWIZZLE_C2D_PINGPONG -- requirements
Module: swizzle_c2d_pingpong

---
 rtl/swizzle_c2d_pingpong.sv | 192 +++++++++++++++++++
 tb/tb_swizzle_c2d_pingpong.sv | 438 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/swizzle_c2d_pingpong.sv
// Corner-turn (CRAM row to DRAM column) swizzle with ping-pong buffers.
// Transpose mode collects up to N words of N bits into one buffer, then drains
// it column by column while the other buffer fills. Pass-through mode forwards
// words straight to the DRAM write port. Both modes share the address counter.
module swizzle_c2d_pingpong #(
    parameter int N      = 40,
    parameter int AWIDTH = 9,
    parameter int LOG_N  = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [N-1:0]      in_data,
    input  logic              in_last,
    input  logic              dma_mode,
    input  logic [AWIDTH-1:0] start_addr,
    output logic              out_we,
    input  logic              out_ready,
    output logic [AWIDTH-1:0] out_addr,
    output logic [N-1:0]      out_data,
    output logic              busy,
    output logic              done
);

    localparam int              IW       = (N > 1) ? $clog2(N) : 1;
    localparam logic [LOG_N-1:0] LAST_IDX = LOG_N'(N - 1);

    typedef enum logic [1:0] {
        BUF_EMPTY,
        BUF_FILLING,
        BUF_FULL,
        BUF_DRAINING
    } bufState_t;

    bufState_t         r_state     [2];
    bufState_t         w_stateNext [2];
    logic              r_wrSel;
    logic              r_rdSel;
    logic [LOG_N-1:0]  r_row;
    logic [LOG_N-1:0]  r_col;
    logic [AWIDTH-1:0] r_addr;
    logic              r_mode;
    logic              r_busy;
    logic              r_done;
    logic [1:0]        r_lastFlag;

    logic [N-1:0]      w_rowQ [2][N];
    logic [N-1:0]      w_column;
    logic              w_mode;
    logic              w_inBeat;
    logic              w_outBeat;
    logic              w_start;
    logic              w_fillBeat;
    logic              w_fillEnd;
    logic              w_drainBeat;
    logic              w_drainEnd;
    logic              w_jobEnd;

    // Buffer storage: a new buffer clears its unused rows while writing row 0,
    // so a short final buffer drains zeros for the rows it never received.
    for (genvar b = 0; b < 2; b++) begin : g_buf
        for (genvar k = 0; k < N; k++) begin : g_row
            logic [N-1:0] r_word;

            // One stored row; written only while its buffer is the fill target.
            always_ff @(posedge clk) begin
                if (w_fillBeat && (r_wrSel == 1'(b))) begin
                    if (r_row == LOG_N'(k)) begin
                        r_word <= in_data;
                    end else if (r_row == '0) begin
                        r_word <= '0;
                    end
                end
            end

            assign w_rowQ[b][k] = r_word;
        end
    end

    // Output and handshake decode; mode comes from the pins until a job latches it.
    always_comb begin
        w_mode   = r_busy ? r_mode : dma_mode;
        w_column = '0;
        for (int k = 0; k < N; k++) begin
            w_column[k] = w_rowQ[r_rdSel][k][r_col[IW-1:0]];
        end
        if (w_mode) begin
            in_ready = out_ready;
            out_we   = in_valid;
            out_data = in_data;
        end else begin
            in_ready = (r_state[r_wrSel] == BUF_EMPTY) || (r_state[r_wrSel] == BUF_FILLING);
            out_we   = (r_state[r_rdSel] == BUF_DRAINING);
            out_data = w_column;
        end
        out_addr    = (w_mode && !r_busy) ? start_addr : r_addr;
        w_inBeat    = in_valid & in_ready;
        w_outBeat   = out_we & out_ready;
        w_start     = w_inBeat & ~r_busy;
        w_fillBeat  = w_inBeat & ~w_mode;
        w_fillEnd   = w_fillBeat & ((r_row == LAST_IDX) | in_last);
        w_drainBeat = w_outBeat & ~w_mode;
        w_drainEnd  = w_drainBeat & (r_col == LAST_IDX);
        w_jobEnd    = w_mode ? (w_outBeat & in_last) : (w_drainEnd & r_lastFlag[r_rdSel]);
    end

    // Per-buffer lifecycle: fill, hold one cycle as FULL, drain, free.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            w_stateNext[i] = r_state[i];
            case (r_state[i])
                BUF_EMPTY, BUF_FILLING: begin
                    if (w_fillBeat && (r_wrSel == 1'(i))) begin
                        w_stateNext[i] = w_fillEnd ? BUF_FULL : BUF_FILLING;
                    end
                end
                BUF_FULL: begin
                    if (r_rdSel == 1'(i)) begin
                        w_stateNext[i] = BUF_DRAINING;
                    end
                end
                BUF_DRAINING: begin
                    if (w_drainEnd && (r_rdSel == 1'(i))) begin
                        w_stateNext[i] = BUF_EMPTY;
                    end
                end
                default: w_stateNext[i] = BUF_EMPTY;
            endcase
        end
    end

    // Buffer state registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state[0] <= BUF_EMPTY;
            r_state[1] <= BUF_EMPTY;
        end else begin
            r_state[0] <= w_stateNext[0];
            r_state[1] <= w_stateNext[1];
        end
    end

    // Row/column counters, buffer selects, address and job bookkeeping.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wrSel    <= 1'b0;
            r_rdSel    <= 1'b0;
            r_row      <= '0;
            r_col      <= '0;
            r_addr     <= '0;
            r_mode     <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_lastFlag <= 2'b00;
        end else begin
            if (w_fillEnd) begin
                r_row               <= '0;
                r_wrSel             <= ~r_wrSel;
                r_lastFlag[r_wrSel] <= in_last;
            end else if (w_fillBeat) begin
                r_row <= r_row + 1'b1;
            end

            if (w_drainEnd) begin
                r_col   <= '0;
                r_rdSel <= ~r_rdSel;
            end else if (w_drainBeat) begin
                r_col <= r_col + 1'b1;
            end

            if (w_outBeat) begin
                r_addr <= out_addr + 1'b1;
            end else if (w_start) begin
                r_addr <= start_addr;
            end

            if (w_start) begin
                r_mode <= dma_mode;
                r_busy <= 1'b1;
            end
            if (w_jobEnd) begin
                r_busy <= 1'b0;
            end
            r_done <= w_jobEnd;
        end
    end

    assign busy = r_busy;
    assign done = r_done;

endmodule

// File: tb/tb_swizzle_c2d_pingpong.sv
// Self-checking bench for swizzle_c2d_pingpong at N=4, AWIDTH=4.
// A job-level reference model (chunk, zero-pad, transpose, count addresses)
// predicts every DRAM beat; a negedge monitor records what the DUT writes.
module tb_swizzle_c2d_pingpong;

    localparam int TN = 4;
    localparam int TA = 4;

    logic          clk;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [TN-1:0] in_data;
    logic          in_last;
    logic          dma_mode;
    logic [TA-1:0] start_addr;
    logic          out_we;
    logic          out_ready;
    logic [TA-1:0] out_addr;
    logic [TN-1:0] out_data;
    logic          busy;
    logic          done;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [3:0] jobWords[$];
    logic [3:0] expAddr[$];
    logic [3:0] expData[$];
    logic [3:0] obsAddr[$];
    logic [3:0] obsData[$];
    int         obsCyc[$];
    int         inCyc[$];
    int         doneCyc[$];
    bit         doneBusy[$];

    swizzle_c2d_pingpong #(.N(TN), .AWIDTH(TA), .LOG_N(3)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_last(in_last), .dma_mode(dma_mode),
        .start_addr(start_addr), .out_we(out_we), .out_ready(out_ready),
        .out_addr(out_addr), .out_data(out_data), .busy(busy), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Record completed handshakes mid-cycle, well away from the rising edge.
    always @(negedge clk) begin
        if (!reset) begin
            if (out_we && out_ready) begin
                obsAddr.push_back(out_addr);
                obsData.push_back(out_data);
                obsCyc.push_back(cyc);
            end
            if (in_valid && in_ready) inCyc.push_back(cyc);
            if (done) begin
                doneCyc.push_back(cyc);
                doneBusy.push_back(busy);
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    function automatic void clear_monitor();
        obsAddr.delete(); obsData.delete(); obsCyc.delete();
        inCyc.delete(); doneCyc.delete(); doneBusy.delete();
    endfunction

    // Job-level model: pass-through copies words; transpose cuts the job into
    // N-word chunks, zero-pads the last one and emits its N columns.
    function automatic void build_expected(input bit mode, input logic [3:0] sa);
        int n;
        logic [3:0] d;
        logic [3:0] w;
        expAddr.delete();
        expData.delete();
        n = jobWords.size();
        if (mode) begin
            for (int i = 0; i < n; i++) expData.push_back(jobWords[i]);
        end else begin
            for (int base = 0; base < n; base += TN) begin
                for (int c = 0; c < TN; c++) begin
                    d = '0;
                    for (int k = 0; k < TN; k++) begin
                        if (base + k < n) begin
                            w = jobWords[base + k];
                            d[k] = w[c];
                        end
                    end
                    expData.push_back(d);
                end
            end
        end
        for (int i = 0; i < expData.size(); i++) expAddr.push_back(sa + 4'(i));
    endfunction

    // Drive one whole job with random valid/ready gaps; scramble mode and
    // start address once the job has started, then let the outputs settle.
    task automatic run_job(input bit mode, input logic [3:0] sa, input int validPct,
                           input int readyPct, output bit timedOut);
        int n;
        int idx;
        int budget;
        bit acc;
        n = jobWords.size();
        idx = 0;
        budget = 0;
        timedOut = 1'b0;
        clear_monitor();
        dma_mode   = mode;
        start_addr = sa;
        in_data    = jobWords[0];
        in_last    = (n == 1);
        in_valid   = (int'($urandom_range(99)) < validPct);
        out_ready  = (int'($urandom_range(99)) < readyPct);
        while (!(idx == n && doneCyc.size() != 0) && !timedOut) begin
            @(negedge clk);
            acc = in_valid && in_ready;
            @(posedge clk);
            #1;
            if (acc) begin
                idx++;
                dma_mode   = 1'($urandom);
                start_addr = 4'($urandom);
            end
            if (idx < n) begin
                in_valid = (int'($urandom_range(99)) < validPct);
                in_data  = jobWords[idx];
                in_last  = (idx == n - 1);
            end else begin
                in_valid = 1'b0;
                in_last  = 1'b0;
                in_data  = 4'($urandom);
            end
            out_ready = (int'($urandom_range(99)) < readyPct);
            budget++;
            if (budget > 400) timedOut = 1'b1;
        end
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        dma_mode  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset      = 1'b1;
        in_valid   = 1'b0;
        in_data    = '0;
        in_last    = 1'b0;
        dma_mode   = 1'b0;
        start_addr = 4'h7;
        out_ready  = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (out_we !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_we: got %b expected 0", out_we); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done: got %b expected 0", done); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_in_ready: got %b expected 1", in_ready); end
        checks++; if (out_addr !== 4'h0) begin errors++; $display("[TB] FAIL reset_out_addr: got %h expected 0", out_addr); end
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (out_we !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL post_reset_idle: got we=%b busy=%b rdy=%b expected 0 0 1", out_we, busy, in_ready);
        end
    endtask

    task automatic test_transpose();
        bit to;
        logic [3:0] sa;
        for (int t = 0; t < 2; t++) begin
            if (t == 0) begin
                jobWords = '{4'h1, 4'h2, 4'h4, 4'h8};
                sa = 4'h3;
            end else begin
                jobWords = '{4'hF, 4'h0, 4'h0, 4'h0, 4'h3};
                sa = 4'h0;
            end
            build_expected(1'b0, sa);
            run_job(1'b0, sa, 100, 100, to);
            checks++; if (to) begin errors++; $display("[TB] FAIL transpose%0d_timeout: job did not complete", t); end
            checks++; if (obsData.size() != expData.size()) begin
                errors++; $display("[TB] FAIL transpose%0d_beats: got %0d expected %0d", t, obsData.size(), expData.size());
            end
            for (int i = 0; i < obsData.size() && i < expData.size(); i++) begin
                checks++;
                if (obsAddr[i] !== expAddr[i] || obsData[i] !== expData[i]) begin
                    errors++;
                    $display("[TB] FAIL transpose%0d_beat%0d: got addr=%h data=%h expected addr=%h data=%h",
                             t, i, obsAddr[i], obsData[i], expAddr[i], expData[i]);
                end
            end
            if (obsCyc.size() > 0 && inCyc.size() >= TN) begin
                checks++;
                if (obsCyc[0] != inCyc[TN-1] + 2) begin
                    errors++; $display("[TB] FAIL transpose%0d_latency: first write cycle %0d expected %0d", t, obsCyc[0], inCyc[TN-1] + 2);
                end
            end
            checks++; if (doneCyc.size() != 1) begin errors++; $display("[TB] FAIL transpose%0d_done_count: got %0d expected 1", t, doneCyc.size()); end
            if (doneCyc.size() > 0 && obsCyc.size() > 0) begin
                checks++;
                if (doneCyc[0] != obsCyc[obsCyc.size()-1] + 1 || doneBusy[0] !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL transpose%0d_done_timing: got cycle %0d busy %b expected cycle %0d busy 0",
                             t, doneCyc[0], doneBusy[0], obsCyc[obsCyc.size()-1] + 1);
                end
            end
        end
    endtask

    task automatic test_wrap();
        bit to;
        jobWords.delete();
        for (int i = 0; i < 8; i++) jobWords.push_back(4'($urandom));
        build_expected(1'b0, 4'hE);
        run_job(1'b0, 4'hE, 100, 100, to);
        checks++; if (to) begin errors++; $display("[TB] FAIL wrap_timeout: job did not complete"); end
        checks++; if (obsData.size() != 8) begin errors++; $display("[TB] FAIL wrap_beats: got %0d expected 8", obsData.size()); end
        for (int i = 0; i < obsData.size() && i < expData.size(); i++) begin
            checks++;
            if (obsAddr[i] !== expAddr[i] || obsData[i] !== expData[i]) begin
                errors++;
                $display("[TB] FAIL wrap_beat%0d: got addr=%h data=%h expected addr=%h data=%h",
                         i, obsAddr[i], obsData[i], expAddr[i], expData[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        int idx;
        int budget;
        bit acc;
        jobWords.delete();
        for (int i = 0; i < 8; i++) jobWords.push_back(4'($urandom));
        build_expected(1'b0, 4'h9);
        clear_monitor();
        dma_mode   = 1'b0;
        start_addr = 4'h9;
        out_ready  = 1'b0;
        in_valid   = 1'b1;
        in_data    = jobWords[0];
        in_last    = 1'b0;
        idx = 0;
        budget = 0;
        while (idx < 8 && budget < 40) begin
            @(negedge clk);
            acc = in_valid && in_ready;
            @(posedge clk);
            #1;
            if (acc) idx++;
            if (idx < 8) begin
                in_data = jobWords[idx];
                in_last = (idx == 7);
            end else begin
                in_valid = 1'b0;
                in_last  = 1'b0;
            end
            budget++;
        end
        in_valid = 1'b0;
        checks++; if (idx != 8) begin errors++; $display("[TB] FAIL bp_fill: accepted %0d words expected 8", idx); end
        repeat (2) @(posedge clk);
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL bp_in_ready: got %b expected 0", in_ready); end
        checks++; if (out_we !== 1'b1 || out_addr !== 4'h9 || out_data !== expData[0]) begin
            errors++; $display("[TB] FAIL bp_hold: got we=%b addr=%h data=%h expected 1 9 %h", out_we, out_addr, out_data, expData[0]);
        end
        repeat (4) @(posedge clk);
        #1;
        checks++; if (out_we !== 1'b1 || out_addr !== 4'h9 || out_data !== expData[0] || in_ready !== 1'b0) begin
            errors++; $display("[TB] FAIL bp_frozen: got we=%b addr=%h data=%h rdy=%b expected 1 9 %h 0",
                               out_we, out_addr, out_data, in_ready, expData[0]);
        end
        checks++; if (obsData.size() != 0) begin errors++; $display("[TB] FAIL bp_no_beats: got %0d expected 0", obsData.size()); end
        out_ready = 1'b1;
        budget = 0;
        while (doneCyc.size() == 0 && budget < 40) begin
            @(posedge clk);
            #1;
            budget++;
        end
        repeat (3) @(posedge clk);
        #1;
        checks++; if (obsData.size() != 8 || doneCyc.size() != 1) begin
            errors++; $display("[TB] FAIL bp_release: got %0d beats %0d done expected 8 beats 1 done", obsData.size(), doneCyc.size());
        end
        for (int i = 0; i < obsData.size() && i < expData.size(); i++) begin
            checks++;
            if (obsAddr[i] !== expAddr[i] || obsData[i] !== expData[i]) begin
                errors++;
                $display("[TB] FAIL bp_beat%0d: got addr=%h data=%h expected addr=%h data=%h",
                         i, obsAddr[i], obsData[i], expAddr[i], expData[i]);
            end
        end
    endtask

    task automatic test_passthrough();
        bit to;
        jobWords = '{4'hA, 4'hB, 4'hC};
        build_expected(1'b1, 4'h5);
        run_job(1'b1, 4'h5, 100, 100, to);
        checks++; if (to) begin errors++; $display("[TB] FAIL pt_timeout: job did not complete"); end
        checks++; if (obsData.size() != 3 || inCyc.size() != 3) begin
            errors++; $display("[TB] FAIL pt_beats: got %0d out %0d in expected 3 3", obsData.size(), inCyc.size());
        end
        for (int i = 0; i < obsData.size() && i < inCyc.size() && i < expData.size(); i++) begin
            checks++;
            if (obsAddr[i] !== expAddr[i] || obsData[i] !== expData[i] || obsCyc[i] != inCyc[i]) begin
                errors++;
                $display("[TB] FAIL pt_beat%0d: got addr=%h data=%h cyc=%0d expected addr=%h data=%h cyc=%0d",
                         i, obsAddr[i], obsData[i], obsCyc[i], expAddr[i], expData[i], inCyc[i]);
            end
        end
        if (doneCyc.size() > 0 && obsCyc.size() > 0) begin
            checks++;
            if (doneCyc.size() != 1 || doneCyc[0] != obsCyc[obsCyc.size()-1] + 1 || doneBusy[0] !== 1'b0) begin
                errors++; $display("[TB] FAIL pt_done: got %0d pulses first at %0d busy %b expected 1 at %0d busy 0",
                                   doneCyc.size(), doneCyc[0], doneBusy[0], obsCyc[obsCyc.size()-1] + 1);
            end
        end
    endtask

    task automatic test_reset_mid_job();
        int budget;
        bit to;
        jobWords.delete();
        for (int i = 0; i < 8; i++) jobWords.push_back(4'($urandom));
        clear_monitor();
        dma_mode   = 1'b0;
        start_addr = 4'h2;
        out_ready  = 1'b1;
        in_valid   = 1'b1;
        budget = 0;
        for (int i = 0; i < 8 && budget < 40; ) begin
            in_data = jobWords[i];
            in_last = (i == 7);
            @(negedge clk);
            if (in_valid && in_ready) i++;
            @(posedge clk);
            #1;
            if (i >= 8) in_valid = 1'b0;
            budget++;
            if (obsData.size() >= 2) break;
        end
        reset    = 1'b1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        #1;
        checks++; if (obsData.size() != 2) begin errors++; $display("[TB] FAIL rst_mid_setup: got %0d beats expected 2", obsData.size()); end
        checks++; if (out_we !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("[TB] FAIL rst_mid_immediate: got we=%b busy=%b rdy=%b expected 0 0 1", out_we, busy, in_ready);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        clear_monitor();
        repeat (6) @(posedge clk);
        #1;
        checks++; if (obsData.size() != 0 || busy !== 1'b0) begin
            errors++; $display("[TB] FAIL rst_mid_quiet: got %0d beats busy %b expected 0 beats busy 0", obsData.size(), busy);
        end
        jobWords.delete();
        for (int i = 0; i < 4; i++) jobWords.push_back(4'($urandom));
        build_expected(1'b0, 4'hB);
        run_job(1'b0, 4'hB, 100, 100, to);
        checks++; if (to || obsData.size() != 4) begin
            errors++; $display("[TB] FAIL rst_mid_newjob: got %0d beats timeout %b expected 4 beats", obsData.size(), to);
        end
        for (int i = 0; i < obsData.size() && i < expData.size(); i++) begin
            checks++;
            if (obsAddr[i] !== expAddr[i] || obsData[i] !== expData[i]) begin
                errors++;
                $display("[TB] FAIL rst_mid_beat%0d: got addr=%h data=%h expected addr=%h data=%h",
                         i, obsAddr[i], obsData[i], expAddr[i], expData[i]);
            end
        end
    endtask

    task automatic test_random();
        bit to;
        bit mode;
        logic [3:0] sa;
        int len;
        for (int j = 0; j < 12; j++) begin
            mode = 1'($urandom);
            sa   = 4'($urandom);
            len  = int'($urandom_range(1, 10));
            jobWords.delete();
            for (int i = 0; i < len; i++) jobWords.push_back(4'($urandom));
            build_expected(mode, sa);
            run_job(mode, sa, int'($urandom_range(50, 100)), int'($urandom_range(40, 100)), to);
            checks++; if (to) begin errors++; $display("[TB] FAIL rand%0d_timeout: mode %b len %0d did not complete", j, mode, len); end
            checks++; if (obsData.size() != expData.size()) begin
                errors++; $display("[TB] FAIL rand%0d_beats: got %0d expected %0d", j, obsData.size(), expData.size());
            end
            for (int i = 0; i < obsData.size() && i < expData.size(); i++) begin
                checks++;
                if (obsAddr[i] !== expAddr[i] || obsData[i] !== expData[i]) begin
                    errors++;
                    $display("[TB] FAIL rand%0d_beat%0d: got addr=%h data=%h expected addr=%h data=%h",
                             j, i, obsAddr[i], obsData[i], expAddr[i], expData[i]);
                end
            end
            checks++; if (doneCyc.size() != 1) begin errors++; $display("[TB] FAIL rand%0d_done_count: got %0d expected 1", j, doneCyc.size()); end
            if (doneCyc.size() > 0 && obsCyc.size() > 0) begin
                checks++;
                if (doneCyc[0] != obsCyc[obsCyc.size()-1] + 1 || doneBusy[0] !== 1'b0) begin
                    errors++; $display("[TB] FAIL rand%0d_done_timing: got cycle %0d busy %b expected cycle %0d busy 0",
                                       j, doneCyc[0], doneBusy[0], obsCyc[obsCyc.size()-1] + 1);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_transpose();
        test_wrap();
        test_backpressure();
        test_passthrough();
        test_reset_mid_job();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
